sprite_addr_cal: RTL and testbench

//  Per-sprite pixel-to-ROM address calculator for the sprite display engines (coin, block, etc.).

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_addr_cal_if.sv | 23 ++
 rtl/span_check.sv | 20 ++
 rtl/sprite_addr_cal.sv | 80 ++++++++
 tb/tb_sprite_addr_cal.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite address calculator.
// Pattern/sprite descriptor structs plus address and coordinate widths.
package sprite_pkg;

  localparam int ADDR_W  = 16;
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] src_w;
    logic [ADDR_W-1:0] src_h;
    logic [ADDR_W-1:0] disp_w;
    logic [ADDR_W-1:0] disp_h;
  } pattern_info_t;

  typedef struct packed {
    logic               visible;
    logic               hflip;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] shift;
  } sprite_info_t;

endpackage

// File: rtl/sprite_addr_cal_if.sv
// Sprite address calculator bus: descriptors + raster in, address/valid out.
// master drives descriptors and raster position; slave is the calculator.
interface sprite_addr_cal_if;
  import sprite_pkg::*;

  pattern_info_t       pattern_info;
  sprite_info_t        sprite_info;
  logic [COORD_W-1:0]  hcount;
  logic [COORD_W-1:0]  vcount;
  logic [ADDR_W-1:0]   addr_output;
  logic                valid;

  modport master (
    output pattern_info, sprite_info, hcount, vcount,
    input  addr_output, valid
  );

  modport slave (
    input  pattern_info, sprite_info, hcount, vcount,
    output addr_output, valid
  );

endinterface

// File: rtl/span_check.sv
// Signed offset d = pos - org and range test 0 <= d < lim.
// Ports: pos, org (11-bit signed), lim (16-bit), d (offset), hit.
module span_check
  import sprite_pkg::*;
(
  input  logic signed [COORD_W:0]  pos,
  input  logic signed [COORD_W:0]  org,
  input  logic [ADDR_W-1:0]        lim,
  output logic signed [COORD_W:0]  d,
  output logic                     hit
);

  logic [ADDR_W-1:0] d_ext;

  assign d     = pos - org;
  assign d_ext = {{(ADDR_W-COORD_W){1'b0}}, d[COORD_W-1:0]};
  // Sign bit set means the pixel is before the origin.
  assign hit   = !d[COORD_W] && (d_ext < lim);

endmodule

// File: rtl/sprite_addr_cal.sv
// Per-sprite pixel-to-ROM address calculator; clk, reset, slave bus.
// SPRITE_ADDR_CAL_COMB_EN: drop output registers (0-cycle, no reset).
module sprite_addr_cal
  import sprite_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int CW = COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  sprite_addr_cal_if.slave   bus
);

  pattern_info_t pi;
  sprite_info_t  si;

  logic [AW-1:0]        ew, eh;
  logic signed [CW:0]   sx, sy;
  logic signed [CW:0]   px, py;
  logic signed [CW:0]   dx, dy;
  logic                 hx, hy, hit;
  logic [AW-1:0]        dx_w, dy_w;
  logic [AW-1:0]        tx, row, addr;

  assign pi = bus.pattern_info;
  assign si = bus.sprite_info;

  assign ew = (pi.src_w < pi.disp_w) ? pi.src_w : pi.disp_w;
  assign eh = (pi.src_h < pi.disp_h) ? pi.src_h : pi.disp_h;

  // shift lets the sprite origin move left of column 0.
  assign sx = $signed({1'b0, si.x}) - $signed({1'b0, si.shift});
  assign sy = $signed({1'b0, si.y});
  assign px = $signed({1'b0, bus.hcount});
  assign py = $signed({1'b0, bus.vcount});

  span_check u_span_x (
    .pos (px),
    .org (sx),
    .lim (ew),
    .d   (dx),
    .hit (hx)
  );

  span_check u_span_y (
    .pos (py),
    .org (sy),
    .lim (eh),
    .d   (dy),
    .hit (hy)
  );

  assign hit  = si.visible & hx & hy;

  // Offsets only matter on a hit, where they are non-negative.
  assign dx_w = {{(AW-CW){1'b0}}, dx[CW-1:0]};
  assign dy_w = {{(AW-CW){1'b0}}, dy[CW-1:0]};

  assign tx   = si.hflip ? (pi.src_w - AW'(1) - dx_w) : dx_w;
  assign row  = dy_w * pi.src_w;
  assign addr = pi.base + row + tx;

`ifdef SPRITE_ADDR_CAL_COMB_EN
  logic unused_ok;
  assign unused_ok       = clk ^ reset;
  assign bus.valid       = hit;
  assign bus.addr_output = hit ? addr : '0;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid       <= 1'b0;
      bus.addr_output <= '0;
    end else begin
      bus.valid       <= hit;
      bus.addr_output <= hit ? addr : '0;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed self-checking bench for sprite_addr_cal (registered build).
// Drives descriptors/raster, checks valid and addr one clk later.
module tb_sprite_addr_cal;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  sprite_addr_cal_if bus ();

  sprite_addr_cal dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic exp_v,
                     input logic [15:0] exp_a);
    total++;
    assert (bus.valid === exp_v) passed++;
    else $error("FAIL %s valid got=%0b exp=%0b",
                tag, bus.valid, exp_v);
    total++;
    assert (bus.addr_output === exp_a) passed++;
    else $error("FAIL %s addr got=%0d exp=%0d",
                tag, bus.addr_output, exp_a);
  endtask

  task automatic set_pat(input logic [15:0] b,
                         input logic [15:0] sw,
                         input logic [15:0] sh,
                         input logic [15:0] dw,
                         input logic [15:0] dh);
    bus.pattern_info = '{base: b, src_w: sw, src_h: sh,
                         disp_w: dw, disp_h: dh};
  endtask

  task automatic set_spr(input logic v, input logic f,
                         input logic [9:0] x,
                         input logic [9:0] y,
                         input logic [9:0] s);
    bus.sprite_info = '{visible: v, hflip: f, x: x,
                        y: y, shift: s};
  endtask

  task automatic set_ras(input logic [9:0] h,
                         input logic [9:0] v);
    bus.hcount = h;
    bus.vcount = v;
  endtask

  initial begin
    set_pat(16'd128, 16'd8, 16'd16, 16'd8, 16'd16);
    set_spr(1'b1, 1'b0, 10'd100, 10'd200, 10'd0);
    set_ras(10'd103, 10'd205);
    reset = 1'b1;
    step();
    chk("reset", 1'b0, 16'd0);
    reset = 1'b0;

    step();
    chk("t1_hit", 1'b1, 16'd171);

    set_spr(1'b1, 1'b1, 10'd100, 10'd200, 10'd0);
    step();
    chk("t2_hflip", 1'b1, 16'd172);

    set_spr(1'b1, 1'b0, 10'd100, 10'd200, 10'd0);
    set_ras(10'd108, 10'd205);
    step();
    chk("t3_right", 1'b0, 16'd0);

    set_ras(10'd103, 10'd216);
    step();
    chk("t3_bottom", 1'b0, 16'd0);

    set_ras(10'd100, 10'd200);
    step();
    chk("t3_origin", 1'b1, 16'd128);

    set_ras(10'd107, 10'd215);
    step();
    chk("t3_last", 1'b1, 16'd255);

    set_ras(10'd99, 10'd200);
    step();
    chk("left_miss", 1'b0, 16'd0);

    set_ras(10'd100, 10'd199);
    step();
    chk("top_miss", 1'b0, 16'd0);

    set_pat(16'd0, 16'd8, 16'd16, 16'd8, 16'd16);
    set_spr(1'b1, 1'b0, 10'd15, 10'd0, 10'd20);
    set_ras(10'd0, 10'd0);
    step();
    chk("t4_clip", 1'b1, 16'd5);

    set_spr(1'b1, 1'b0, 10'd10, 10'd0, 10'd20);
    step();
    chk("t4_off", 1'b0, 16'd0);

    set_pat(16'd128, 16'd8, 16'd16, 16'd8, 16'd16);
    set_spr(1'b0, 1'b0, 10'd100, 10'd200, 10'd0);
    set_ras(10'd103, 10'd205);
    step();
    chk("t5_invis", 1'b0, 16'd0);

    set_pat(16'd128, 16'd8, 16'd16, 16'd4, 16'd16);
    set_spr(1'b1, 1'b0, 10'd100, 10'd200, 10'd0);
    set_ras(10'd105, 10'd205);
    step();
    chk("t5_dispw", 1'b0, 16'd0);

    set_ras(10'd103, 10'd205);
    step();
    chk("t5_dispw_in", 1'b1, 16'd171);

    set_pat(16'd128, 16'd0, 16'd16, 16'd8, 16'd16);
    step();
    chk("src_w_zero", 1'b0, 16'd0);

    set_pat(16'hFFFF, 16'd8, 16'd16, 16'd8, 16'd16);
    set_ras(10'd101, 10'd200);
    step();
    chk("wrap", 1'b1, 16'd0);

    set_pat(16'd128, 16'd8, 16'd16, 16'd8, 16'd16);
    set_ras(10'd103, 10'd205);
    step();
    chk("t6_pre", 1'b1, 16'd171);

    reset = 1'b1;
    step();
    chk("t6_reset", 1'b0, 16'd0);

    reset = 1'b0;
    step();
    chk("t6_resume", 1'b1, 16'd171);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
